// File: rtl/idma_inoc_rd_sched_pkg.sv
// Shared types and constants for the iDMA iNoC ibuffer read scheduler.
//   state_e      : scheduler FSM state encoding (3 bits)
//   MAX_WORD_LEN : width of a command word count
package idma_inoc_rd_sched_pkg;

    localparam int unsigned MAX_WORD_LEN = 13;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        BUSY  = 3'd2,
        DONE  = 3'd3,
        FLUSH = 3'd4
    } state_e;

endpackage

// File: rtl/idma_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping.
//   req   : request vector
//   ptr   : highest-priority index this round
//   grant : one-hot grant (zero when no request)
//   idx   : encoded index of the grant (zero when no request)
module idma_rr_arbiter #(
    parameter int unsigned N  = 2,
    parameter int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);

    int unsigned j;
    logic        found;

    // Scan N positions starting at ptr; the first hit wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int unsigned i = 0; i < N; i++) begin
            j = (32'(ptr) + i) % N;
            if (!found && req[j]) begin
                grant[j] = 1'b1;
                idx      = IW'(j);
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/idma_inoc_rd_sched.sv
// Command scheduler in front of the iDMA iNoC ibuffer read unit.
// Arbitrates word-granular read commands round-robin, pulses the read unit,
// waits for return_done and reports completion to the granted requester.
// Optional watchdog: define IDMA_RD_SCHED_TIMEOUT_EN to abort a BUSY command
// after 2**TIMEOUT_W-1 cycles without return_done.
//   req_valid/req_ready          : per-requester handshake (ready is combinational)
//   req_word_addr/num/last       : packed per-requester command fields
//   abort                        : flush the command in START/BUSY
//   ibuffer_rd_start/word_addr/num : read unit command
//   return_done                  : read unit finished
//   op_last_or_finish            : operation end / invalidate pulse
//   done_valid/id/err            : completion report
//   busy                         : scheduler not idle
module idma_inoc_rd_sched
    import idma_inoc_rd_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 2,
    parameter int unsigned MEM_AW    = 15,
    parameter int unsigned WORD_NUM  = 4,
    parameter int unsigned WA_W      = MEM_AW + $clog2(WORD_NUM),
`ifdef IDMA_RD_SCHED_TIMEOUT_EN
    parameter int unsigned TIMEOUT_W = 16,
`endif
    parameter int unsigned ID_W      = $clog2(NUM_REQ)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ*WA_W-1:0]         req_word_addr,
    input  logic [NUM_REQ*MAX_WORD_LEN-1:0] req_word_num,
    input  logic [NUM_REQ-1:0]              req_last,
    input  logic                            abort,
    output logic                            ibuffer_rd_start,
    output logic [WA_W-1:0]                 ibuffer_word_addr,
    output logic [MAX_WORD_LEN-1:0]         ibuffer_word_num,
    output logic                            op_last_or_finish,
    input  logic                            return_done,
    output logic                            done_valid,
    output logic [ID_W-1:0]                 done_id,
    output logic                            done_err,
    output logic                            busy
);

    state_e                  state, state_nxt;
    logic [ID_W-1:0]         ptr;
    logic [NUM_REQ-1:0]      gnt_oh;
    logic [ID_W-1:0]         gnt_idx;
    logic                    gnt_any_c;
    logic [WA_W-1:0]         sel_addr_c;
    logic [MAX_WORD_LEN-1:0] sel_num_c;
    logic                    cmd_last;
    logic [ID_W-1:0]         cmd_id;
    logic                    fin_last_c;
    logic [ID_W-1:0]         fin_id_c;
    logic                    fin_err_c;
    logic                    fin_c;
    logic                    to_hit_c;

    idma_rr_arbiter #(
        .N  (NUM_REQ),
        .IW (ID_W)
    ) u_arb (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (gnt_oh),
        .idx   (gnt_idx)
    );

    assign gnt_any_c  = |req_valid;
    assign sel_addr_c = req_word_addr[32'(gnt_idx) * WA_W +: WA_W];
    assign sel_num_c  = req_word_num[32'(gnt_idx) * MAX_WORD_LEN +: MAX_WORD_LEN];

`ifdef IDMA_RD_SCHED_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] to_cnt;

    // Held at zero outside BUSY so it is clear on every BUSY entry; the hit
    // fires on the cycle the count steps to all-ones.
    assign to_hit_c = !return_done && (to_cnt == ~TIMEOUT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
        end else if (state != BUSY) begin
            to_cnt <= '0;
        end else if (!return_done) begin
            to_cnt <= to_cnt + TIMEOUT_W'(1);
        end
    end
`else
    assign to_hit_c = 1'b0;
`endif

    // Next state, grant and completion attributes; in IDLE the completion
    // attributes come straight from the granted request (zero-length path).
    always_comb begin
        state_nxt  = state;
        req_ready  = '0;
        fin_last_c = cmd_last;
        fin_id_c   = cmd_id;
        fin_err_c  = 1'b0;
        case (state)
            IDLE: begin
                if (gnt_any_c) begin
                    req_ready  = gnt_oh;
                    fin_last_c = req_last[gnt_idx];
                    fin_id_c   = gnt_idx;
                    fin_err_c  = (sel_num_c == '0);
                    state_nxt  = (sel_num_c == '0) ? DONE : START;
                end
            end
            START:   state_nxt = abort ? FLUSH : BUSY;
            BUSY: begin
                if (return_done) begin
                    state_nxt = DONE;
                end else if (abort || to_hit_c) begin
                    state_nxt = FLUSH;
                end
            end
            DONE:    state_nxt = IDLE;
            FLUSH:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign fin_c = (state_nxt == DONE) || (state_nxt == FLUSH);

    // State, command latches and registered outputs aligned with the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            ptr               <= '0;
            cmd_last          <= 1'b0;
            cmd_id            <= '0;
            ibuffer_word_addr <= '0;
            ibuffer_word_num  <= '0;
            ibuffer_rd_start  <= 1'b0;
            op_last_or_finish <= 1'b0;
            done_valid        <= 1'b0;
            done_id           <= '0;
            done_err          <= 1'b0;
            busy              <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && gnt_any_c) begin
                ptr               <= (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
                cmd_last          <= req_last[gnt_idx];
                cmd_id            <= gnt_idx;
                ibuffer_word_addr <= sel_addr_c;
                ibuffer_word_num  <= sel_num_c;
            end
            ibuffer_rd_start  <= (state_nxt == START);
            done_valid        <= fin_c;
            done_id           <= fin_c ? fin_id_c : '0;
            done_err          <= (state_nxt == FLUSH) || ((state_nxt == DONE) && fin_err_c);
            op_last_or_finish <= (state_nxt == FLUSH) || ((state_nxt == DONE) && fin_last_c);
            busy              <= (state_nxt != IDLE);
        end
    end

endmodule

// File: tb/tb_idma_inoc_rd_sched.sv
// Directed testbench for idma_inoc_rd_sched (NUM_REQ=2, WA_W=17).
module tb_idma_inoc_rd_sched;

    localparam int unsigned WA_W = 17;
    localparam int unsigned NW   = 13;

    logic            clk;
    logic            rst_n;
    logic [1:0]      req_valid;
    logic [1:0]      req_ready;
    logic [2*WA_W-1:0] req_word_addr;
    logic [2*NW-1:0] req_word_num;
    logic [1:0]      req_last;
    logic            abort;
    logic            ibuffer_rd_start;
    logic [WA_W-1:0] ibuffer_word_addr;
    logic [NW-1:0]   ibuffer_word_num;
    logic            op_last_or_finish;
    logic            return_done;
    logic            done_valid;
    logic [0:0]      done_id;
    logic            done_err;
    logic            busy;

    int errors = 0;
    int checks = 0;

    idma_inoc_rd_sched #(
        .NUM_REQ   (2),
        .MEM_AW    (15),
        .WORD_NUM  (4)
`ifdef IDMA_RD_SCHED_TIMEOUT_EN
        , .TIMEOUT_W (4)
`endif
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_word_addr     (req_word_addr),
        .req_word_num      (req_word_num),
        .req_last          (req_last),
        .abort             (abort),
        .ibuffer_rd_start  (ibuffer_rd_start),
        .ibuffer_word_addr (ibuffer_word_addr),
        .ibuffer_word_num  (ibuffer_word_num),
        .op_last_or_finish (op_last_or_finish),
        .return_done       (return_done),
        .done_valid        (done_valid),
        .done_id           (done_id),
        .done_err          (done_err),
        .busy              (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [WA_W-1:0] a,
                           input logic [NW-1:0] n, input logic l);
        req_valid[i]               = v;
        req_word_addr[i*WA_W +: WA_W] = a;
        req_word_num[i*NW +: NW]   = n;
        req_last[i]                = l;
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        req_valid     = '0;
        req_word_addr = '0;
        req_word_num  = '0;
        req_last      = '0;
        abort         = 1'b0;
        return_done   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [7:0] outs;
        rst_n = 1'b0;
        req_valid = '0; req_word_addr = '0; req_word_num = '0; req_last = '0;
        abort = 1'b0; return_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        outs = {req_ready, ibuffer_rd_start, op_last_or_finish, done_valid, done_id, done_err, busy};
        checks++;
        if (outs !== 8'h00) begin
            errors++; $display("FAIL reset_ctrl: got %h expected 00", outs);
        end
        checks++;
        if ({ibuffer_word_addr, ibuffer_word_num} !== 30'h0) begin
            errors++; $display("FAIL reset_cmd: got addr %h num %h expected 0 0", ibuffer_word_addr, ibuffer_word_num);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        logic seen;
        do_reset();
        set_req(0, 1'b1, 17'h00005, 13'd7, 1'b1);
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++; $display("FAIL single_grant: got %b expected 01", req_ready);
        end
        tick();
        set_req(0, 1'b0, 17'h0, 13'd0, 1'b0);
        checks++;
        if ({ibuffer_rd_start, ibuffer_word_addr, ibuffer_word_num, busy} !== {1'b1, 17'h00005, 13'd7, 1'b1}) begin
            errors++; $display("FAIL single_start: got start %b addr %h num %0d busy %b expected 1 00005 7 1",
                               ibuffer_rd_start, ibuffer_word_addr, ibuffer_word_num, busy);
        end
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ibuffer_rd_start || done_valid || req_ready != 2'b00) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++; $display("FAIL single_wait: got activity %b expected 0", seen);
        end
        return_done = 1'b1;
        tick();
        return_done = 1'b0;
        checks++;
        if ({done_valid, done_id, done_err, op_last_or_finish} !== 4'b1001) begin
            errors++; $display("FAIL single_done: got %b expected 1001", {done_valid, done_id, done_err, op_last_or_finish});
        end
        checks++;
        if ({ibuffer_word_addr, ibuffer_word_num} !== {17'h00005, 13'd7}) begin
            errors++; $display("FAIL single_hold: got addr %h num %0d expected 00005 7", ibuffer_word_addr, ibuffer_word_num);
        end
        tick();
        checks++;
        if ({done_valid, op_last_or_finish, busy} !== 3'b000) begin
            errors++; $display("FAIL single_idle: got %b expected 000", {done_valid, op_last_or_finish, busy});
        end
    endtask

    task automatic test_fairness();
        logic [1:0] exp;
        do_reset();
        set_req(0, 1'b1, 17'h00100, 13'd3, 1'b0);
        set_req(1, 1'b1, 17'h00200, 13'd4, 1'b0);
        #1;
        for (int k = 0; k < 4; k++) begin
            exp = (k % 2 == 0) ? 2'b01 : 2'b10;
            checks++;
            if (req_ready !== exp) begin
                errors++; $display("FAIL fair_grant%0d: got %b expected %b", k, req_ready, exp);
            end
            tick();
            checks++;
            if (ibuffer_word_addr !== ((k % 2 == 0) ? 17'h00100 : 17'h00200)) begin
                errors++; $display("FAIL fair_addr%0d: got %h", k, ibuffer_word_addr);
            end
            tick();
            return_done = 1'b1;
            tick();
            return_done = 1'b0;
            checks++;
            if ({done_valid, done_id, req_ready} !== {1'b1, exp[1], 2'b00}) begin
                errors++; $display("FAIL fair_done%0d: got %b expected %b", k, {done_valid, done_id, req_ready}, {1'b1, exp[1], 2'b00});
            end
            tick();
            #1;
        end
        req_valid = '0;
    endtask

    task automatic test_zero_len();
        do_reset();
        set_req(1, 1'b1, 17'h00010, 13'd0, 1'b0);
        #1;
        checks++;
        if (req_ready !== 2'b10) begin
            errors++; $display("FAIL zero_grant: got %b expected 10", req_ready);
        end
        tick();
        set_req(1, 1'b0, 17'h0, 13'd0, 1'b0);
        checks++;
        if ({ibuffer_rd_start, done_valid, done_id, done_err, op_last_or_finish} !== 5'b01110) begin
            errors++; $display("FAIL zero_done: got %b expected 01110",
                               {ibuffer_rd_start, done_valid, done_id, done_err, op_last_or_finish});
        end
        tick();
        checks++;
        if ({ibuffer_rd_start, done_valid, busy} !== 3'b000) begin
            errors++; $display("FAIL zero_idle: got %b expected 000", {ibuffer_rd_start, done_valid, busy});
        end
    endtask

    task automatic test_abort();
        do_reset();
        abort = 1'b1;
        return_done = 1'b1;
        tick();
        abort = 1'b0;
        return_done = 1'b0;
        checks++;
        if ({busy, done_valid, op_last_or_finish} !== 3'b000) begin
            errors++; $display("FAIL abort_idle_ignored: got %b expected 000", {busy, done_valid, op_last_or_finish});
        end
        set_req(0, 1'b1, 17'h00123, 13'd9, 1'b0);
        tick();
        set_req(0, 1'b0, 17'h0, 13'd0, 1'b0);
        repeat (5) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if ({done_valid, done_id, done_err, op_last_or_finish, ibuffer_rd_start} !== 5'b10110) begin
            errors++; $display("FAIL abort_flush: got %b expected 10110",
                               {done_valid, done_id, done_err, op_last_or_finish, ibuffer_rd_start});
        end
        tick();
        set_req(1, 1'b1, 17'h00042, 13'd2, 1'b1);
        #1;
        checks++;
        if ({busy, req_ready} !== 3'b010) begin
            errors++; $display("FAIL abort_regrant: got %b expected 010", {busy, req_ready});
        end
        tick();
        set_req(1, 1'b0, 17'h0, 13'd0, 1'b0);
        checks++;
        if ({ibuffer_rd_start, ibuffer_word_addr, ibuffer_word_num} !== {1'b1, 17'h00042, 13'd2}) begin
            errors++; $display("FAIL abort_restart: got start %b addr %h num %0d expected 1 00042 2",
                               ibuffer_rd_start, ibuffer_word_addr, ibuffer_word_num);
        end
        tick();
        return_done = 1'b1;
        tick();
        return_done = 1'b0;
        checks++;
        if ({done_valid, done_id, done_err, op_last_or_finish} !== 4'b1101) begin
            errors++; $display("FAIL abort_next_done: got %b expected 1101", {done_valid, done_id, done_err, op_last_or_finish});
        end
        tick();
    endtask

    task automatic test_race();
        do_reset();
        set_req(0, 1'b1, 17'h00777, 13'd4, 1'b0);
        tick();
        set_req(0, 1'b0, 17'h0, 13'd0, 1'b0);
        tick();
        return_done = 1'b1;
        abort = 1'b1;
        tick();
        return_done = 1'b0;
        abort = 1'b0;
        checks++;
        if ({done_valid, done_err, op_last_or_finish} !== 3'b100) begin
            errors++; $display("FAIL race_done: got %b expected 100", {done_valid, done_err, op_last_or_finish});
        end
        tick();
    endtask

    task automatic test_mid_reset();
        do_reset();
        set_req(0, 1'b1, 17'h00033, 13'd3, 1'b1);
        tick();
        set_req(0, 1'b0, 17'h0, 13'd0, 1'b0);
        tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done_valid, op_last_or_finish, ibuffer_rd_start} !== 4'b0000) begin
            errors++; $display("FAIL midreset: got %b expected 0000", {busy, done_valid, op_last_or_finish, ibuffer_rd_start});
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_timeout();
        logic seen;
        do_reset();
        set_req(0, 1'b1, 17'h00001, 13'd1, 1'b0);
        tick();
        set_req(0, 1'b0, 17'h0, 13'd0, 1'b0);
`ifdef IDMA_RD_SCHED_TIMEOUT_EN
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (done_valid || !busy) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++; $display("FAIL timeout_early: got early exit %b expected 0", seen);
        end
        tick();
        checks++;
        if ({done_valid, done_err, op_last_or_finish} !== 3'b111) begin
            errors++; $display("FAIL timeout_flush: got %b expected 111", {done_valid, done_err, op_last_or_finish});
        end
        tick();
`else
        seen = 1'b0;
        for (int i = 0; i < 120; i++) begin
            tick();
            if (done_valid || !busy) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++; $display("FAIL no_timeout: got exit %b expected 0", seen);
        end
        return_done = 1'b1;
        tick();
        return_done = 1'b0;
        checks++;
        if ({done_valid, done_err} !== 2'b10) begin
            errors++; $display("FAIL no_timeout_done: got %b expected 10", {done_valid, done_err});
        end
        tick();
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_zero_len();
        test_abort();
        test_race();
        test_mid_reset();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
